// File: rtl/clkgen_fracdiv.sv
// clkgen_fracdiv: NUM_CH fractional strobes (ce, clk_sq) from refclk at inc/2^ACC_W with phase load, resync and settle-based locked; CLKGEN_FALL_CE_EN adds ce_fall
module clkgen_fracdiv #(
  parameter int NUM_CH = 5,
  parameter int ACC_W = 24,
  parameter int SETTLE = 1024
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic [NUM_CH*ACC_W-1:0] cfg_inc,
  input  logic [NUM_CH*ACC_W-1:0] cfg_phase,
  input  logic [NUM_CH-1:0]       cfg_en,
  input  logic                    resync,
  output logic [NUM_CH-1:0]       ce,
`ifdef CLKGEN_FALL_CE_EN
  output logic [NUM_CH-1:0]       ce_fall,
`endif
  output logic [NUM_CH-1:0]       clk_sq,
  output logic                    locked
);
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
  logic [ACC_W-1:0] acc [NUM_CH];
  logic [ACC_W:0] sum [NUM_CH];
  logic [NUM_CH*ACC_W-1:0] inc_shadow;
  logic [CW-1:0] cnt, cnt_nxt;
  logic stable;
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, acc[i]} + {1'b0, cfg_inc[i*ACC_W +: ACC_W]};
      clk_sq[i] = acc[i][ACC_W-1];
    end
  end
  assign stable = cfg_inc == inc_shadow;
  assign cnt_nxt = (cnt == SETTLE_C) ? cnt : cnt + 1'b1;
  always_ff @(posedge refclk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst || resync) begin
        acc[i] <= cfg_phase[i*ACC_W +: ACC_W];
        ce[i] <= 1'b0;
      end else if (cfg_en[i]) begin
        acc[i] <= sum[i][ACC_W-1:0];
        ce[i] <= sum[i][ACC_W];
      end else begin
        ce[i] <= 1'b0;
      end
`ifdef CLKGEN_FALL_CE_EN
      ce_fall[i] <= !(rst || resync) && cfg_en[i] && !acc[i][ACC_W-1] && sum[i][ACC_W-1];
`endif
    end
    if (rst || resync || !stable) begin
      inc_shadow <= cfg_inc;
      cnt <= '0;
      locked <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      locked <= cnt_nxt == SETTLE_C;
    end
  end
endmodule

// File: tb/tb_clkgen_fracdiv.sv
// tb_clkgen_fracdiv: directed vector table plus multi-cycle sequences for clkgen_fracdiv
module tb_clkgen_fracdiv;
  localparam int N = 2;
  localparam int W = 8;
  localparam int S = 16;
  logic refclk = 1'b0;
  logic rst = 1'b1;
  logic resync = 1'b0;
  logic [N*W-1:0] cfg_inc = '0;
  logic [N*W-1:0] cfg_phase = '0;
  logic [N-1:0] cfg_en = '0;
  logic [N-1:0] ce, clk_sq;
  logic locked;
`ifdef CLKGEN_FALL_CE_EN
  logic [N-1:0] ce_fall;
`endif
  int checks = 0;
  int errors = 0;
  always #5 refclk = ~refclk;
  clkgen_fracdiv #(.NUM_CH(N), .ACC_W(W), .SETTLE(S)) dut (
    .refclk(refclk),
    .rst(rst),
    .cfg_inc(cfg_inc),
    .cfg_phase(cfg_phase),
    .cfg_en(cfg_en),
    .resync(resync),
    .ce(ce),
`ifdef CLKGEN_FALL_CE_EN
    .ce_fall(ce_fall),
`endif
    .clk_sq(clk_sq),
    .locked(locked)
  );
  typedef struct {
    logic [7:0] inc0, inc1, ph0, ph1;
    logic [1:0] en;
    int n;
    logic [1:0] ce, sq;
    logic lk;
  } vec_t;
  vec_t v [12];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask
  task automatic setup(input logic [7:0] i0, input logic [7:0] i1, input logic [7:0] p0, input logic [7:0] p1, input logic [1:0] en);
    cfg_inc = {i1, i0};
    cfg_phase = {p1, p0};
    cfg_en = en;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    int cnt, last, bad;
    v[0]  = '{64, 0, 0, 0, 2'b11, 0, 2'b00, 2'b00, 1'b0};
    v[1]  = '{64, 0, 0, 0, 2'b11, 2, 2'b00, 2'b01, 1'b0};
    v[2]  = '{64, 0, 0, 0, 2'b11, 4, 2'b01, 2'b00, 1'b0};
    v[3]  = '{64, 0, 0, 0, 2'b11, 15, 2'b00, 2'b01, 1'b0};
    v[4]  = '{64, 0, 0, 0, 2'b11, 16, 2'b01, 2'b00, 1'b1};
    v[5]  = '{64, 64, 0, 128, 2'b11, 2, 2'b10, 2'b01, 1'b0};
    v[6]  = '{255, 1, 0, 0, 2'b11, 1, 2'b00, 2'b01, 1'b0};
    v[7]  = '{255, 1, 0, 0, 2'b11, 2, 2'b01, 2'b01, 1'b0};
    v[8]  = '{1, 0, 255, 200, 2'b11, 1, 2'b01, 2'b10, 1'b0};
    v[9]  = '{64, 0, 192, 0, 2'b00, 5, 2'b00, 2'b01, 1'b0};
    v[10] = '{96, 0, 0, 0, 2'b11, 3, 2'b01, 2'b00, 1'b0};
    v[11] = '{0, 0, 128, 0, 2'b00, 40, 2'b00, 2'b01, 1'b1};
    for (int k = 0; k < 12; k++) begin
      setup(v[k].inc0, v[k].inc1, v[k].ph0, v[k].ph1, v[k].en);
      for (int c = 0; c < v[k].n; c++) tick();
      chk($sformatf("vec%0d ce", k), 32'(ce), 32'(v[k].ce));
      chk($sformatf("vec%0d clk_sq", k), 32'(clk_sq), 32'(v[k].sq));
      chk($sformatf("vec%0d locked", k), 32'(locked), 32'(v[k].lk));
    end
    setup(96, 0, 0, 0, 2'b01);
    cnt = 0;
    last = 0;
    bad = 0;
    for (int c = 1; c <= 256; c++) begin
      tick();
      if (ce[0]) begin
        cnt++;
        if (last != 0 && (c - last < 2 || c - last > 3)) bad++;
        last = c;
      end
    end
    chk("frac count", 32'(cnt), 32'd96);
    chk("frac gaps", 32'(bad), 32'd0);
    chk("frac last", 32'(last), 32'd256);
    setup(64, 0, 0, 0, 2'b11);
    for (int c = 1; c <= 20; c++) tick();
    chk("lock pre ce", 32'(ce[0]), 32'd1);
    chk("lock pre locked", 32'(locked), 32'd1);
    cfg_inc = {8'd0, 8'd32};
    for (int c = 21; c <= 40; c++) begin
      tick();
      chk($sformatf("relock ce c%0d", c), 32'(ce[0]), 32'(c == 28 || c == 36));
      chk($sformatf("relock locked c%0d", c), 32'(locked), 32'(c >= 37));
    end
    setup(64, 32, 0, 128, 2'b11);
    for (int c = 0; c < 5; c++) tick();
    resync = 1'b1;
    cfg_inc = {8'd64, 8'd64};
    tick();
    resync = 1'b0;
    chk("resync ce0", 32'(ce), 32'd0);
    chk("resync locked0", 32'(locked), 32'd0);
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk($sformatf("resync ce c%0d", c), 32'(ce), 32'({c % 4 == 2, c % 4 == 0}));
      chk($sformatf("resync locked c%0d", c), 32'(locked), 32'(c == 16));
    end
    setup(64, 0, 0, 0, 2'b11);
    tick();
    tick();
    chk("gate sq at 128", 32'(clk_sq[0]), 32'd1);
    cfg_en = 2'b10;
    for (int c = 3; c <= 12; c++) begin
      tick();
      chk($sformatf("gate off ce c%0d", c), 32'(ce[0]), 32'd0);
      chk($sformatf("gate off sq c%0d", c), 32'(clk_sq[0]), 32'd1);
    end
    cfg_en = 2'b11;
    for (int c = 13; c <= 16; c++) begin
      tick();
      chk($sformatf("gate on ce c%0d", c), 32'(ce[0]), 32'(c == 14));
    end
    setup(64, 0, 0, 0, 2'b11);
    for (int c = 0; c < 3; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst abort ce", 32'(ce), 32'd0);
    chk("rst abort sq", 32'(clk_sq), 32'd0);
`ifdef CLKGEN_FALL_CE_EN
    setup(64, 0, 0, 0, 2'b11);
    chk("ce_fall reset", 32'(ce_fall), 32'd0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk($sformatf("ce_fall c%0d", c), 32'(ce_fall), 32'(c % 4 == 2));
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
